alu_result_buffer: RTL and testbench
====================================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameters SHALL be:
  DEPTH, 4, FIFO entry count; power of two, 2..16.
  ACC_W, 8, accumulator width in bits.
REQ-002 Ports SHALL be:
  clk  input  1  single clock; all state changes on its rising edge.
  rst_n  input  1  asynchronous, active-low reset.
  in_valid  input  1  upstream simple_alu result is presented.
  in_ready  output  1  buffer can accept an entry this cycle.
  in_y  input  4  ALU result y.
  in_c  input  1  ALU carry c.
  in_op  input  2  ctrl code that produced the result.
  out_valid  output  1  head entry available.
  out_ready  input  1  downstream accepts the head entry.
  out_data  output  7  head entry, {op[1:0], c, y[3:0]}.
  acc_clr  input  1  synchronous accumulator clear.
  acc  output  ACC_W  running sum of accepted y values.
  carry_cnt  output  4  count of accepted entries with c=1, saturating at 15.
  level  output  log2(DEPTH)+1  current occupancy.
  overflow  output  1  sticky: push attempted while full.

Function
REQ-003 Push SHALL occur on a clock edge where in_valid && in_ready.
REQ-004 Pop SHALL occur on a clock edge where out_valid && out_ready.
REQ-005 in_ready SHALL equal (level != DEPTH), combinational from state only, not from out_ready.
REQ-006 out_valid SHALL equal (level != 0); out_data SHALL show the oldest entry combinationally from storage.
REQ-007 Storage SHALL be a circular buffer with write and read pointers that wrap from DEPTH-1 to 0.
REQ-008 Push and pop on the same edge SHALL leave level unchanged, write the new entry, and advance both pointers.
REQ-009 When full, in_ready=0 and no push SHALL occur, even if a pop occurs on the same edge.
REQ-010 When empty, out_valid=0 and out_ready SHALL have no effect.
REQ-011 The first pushed entry SHALL appear on out_data with out_valid=1 one cycle after its push edge; there is no flow-through path.
REQ-012 On each push, acc SHALL take acc + zero-extended in_y, wrapping modulo 2^ACC_W.
REQ-013 acc_clr=1 SHALL set acc to 0; with a simultaneous push, acc SHALL load the zero-extended in_y instead.
REQ-014 On each push with in_c=1, carry_cnt SHALL increment, holding at 15; acc_clr SHALL also clear carry_cnt, and a simultaneous push with in_c=1 SHALL load 1.
REQ-015 overflow SHALL set on any edge with in_valid=1 while level==DEPTH and SHALL stay set until reset.
REQ-016 Pops SHALL NOT alter acc or carry_cnt.

Reset
REQ-017 rst_n low SHALL immediately, without waiting for clk, force: pointers 0, level 0, in_ready 1, out_valid 0, acc 0, carry_cnt 0, overflow 0.
REQ-018 Storage contents need not be reset; out_data is don't-care while out_valid=0.
REQ-019 Reset asserted mid-transfer SHALL discard all buffered entries; the first edge after rst_n rises SHALL behave as on an empty buffer.

Verification
REQ-020 Push {op=00,c=0,y=0011} with out_ready=0 -> next cycle: out_valid=1, out_data=7'b0000011, level=1, acc=3.
REQ-021 Push y=2,4,6,8 with c=0,1,0,1 (DEPTH=4), out_ready=0 -> level=4, in_ready=0, acc=20, carry_cnt=2; a fifth in_valid sets overflow=1 and leaves acc=20.
REQ-022 From full, out_ready=1 for four cycles -> out_data y sequence 2,4,6,8, then out_valid=0, level=0, acc still 20.
REQ-023 Level 2, push and pop on the same edge -> level stays 2, head advances, new entry is read out third; repeat 10 times to exercise pointer wrap, with no loss or reordering.
REQ-024 acc=250, push y=15 -> acc=9 (wrap); then acc_clr with push y=5 -> acc=5, carry_cnt per REQ-014.
REQ-025 Assert rst_n=0 between clock edges at level 3 with overflow=1 -> all outputs take REQ-017 values before the next edge; after release, a push appears at the head one cycle later.

Source files
------------

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: circular FIFO for simple_alu results with a running sum of
// accepted y values, a saturating carry counter and a sticky overflow flag.
`default_nettype none

module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_y,
  input  logic                       in_c,
  input  logic [1:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [6:0]                 out_data,
  input  logic                       acc_clr,
  output logic [ACC_W-1:0]           acc,
  output logic [3:0]                 carry_cnt,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [LVL_W-1:0] C_FULL = LVL_W'(DEPTH);

  logic [6:0]       mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [ACC_W-1:0] r_acc;
  logic [3:0]       r_carry_cnt;
  logic             r_overflow;

  logic             w_push;
  logic             w_pop;
  logic [ACC_W-1:0] w_y_ext;

  assign in_ready  = (r_level != C_FULL);
  assign out_valid = (r_level != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_y_ext   = ACC_W'(in_y);

  assign out_data  = mem[r_rd_ptr];
  assign level     = r_level;
  assign acc       = r_acc;
  assign carry_cnt = r_carry_cnt;
  assign overflow  = r_overflow;

  // Storage is left unreset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem[r_wr_ptr] <= {in_op, in_c, in_y};
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_carry_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (acc_clr) begin
        r_acc       <= w_push ? w_y_ext : '0;
        r_carry_cnt <= (w_push && in_c) ? 4'd1 : 4'd0;
      end else if (w_push) begin
        r_acc <= r_acc + w_y_ext;
        if (in_c && (r_carry_cnt != 4'hF)) begin
          r_carry_cnt <= r_carry_cnt + 4'd1;
        end
      end
      if (in_valid && (r_level == C_FULL)) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
`default_nettype none

module tb_alu_result_buffer;

  localparam int DEPTH = 4;
  localparam int ACC_W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_y;
  logic       in_c;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic       acc_clr;
  logic [ACC_W-1:0] acc;
  logic [3:0] carry_cnt;
  logic [$clog2(DEPTH):0] level;
  logic       overflow;

  alu_result_buffer #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_c(in_c), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .acc_clr(acc_clr), .acc(acc), .carry_cnt(carry_cnt),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [6:0] q_m[$];
  int  acc_m;
  int  cnt_m;
  bit  ovf_m;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic model_reset();
    q_m.delete();
    acc_m = 0;
    cnt_m = 0;
    ovf_m = 0;
  endtask

  task automatic check_outputs();
    chk("level", level, q_m.size());
    chk("in_ready", in_ready, (q_m.size() != DEPTH) ? 1 : 0);
    chk("out_valid", out_valid, (q_m.size() != 0) ? 1 : 0);
    if (q_m.size() != 0) chk("out_data", out_data, q_m[0]);
    chk("acc", acc, acc_m);
    chk("carry_cnt", carry_cnt, cnt_m);
    chk("overflow", overflow, ovf_m);
  endtask

  // Called at posedge+1: drive, check state-only outputs, advance model, clock.
  task automatic step(input bit v, input int y, input bit c, input int op,
                      input bit ordy, input bit clr);
    bit push, pop;
    in_valid  = v;
    in_y      = 4'(y);
    in_c      = c;
    in_op     = 2'(op);
    out_ready = ordy;
    acc_clr   = clr;
    #1;
    check_outputs();
    push = v && (q_m.size() < DEPTH);
    pop  = ordy && (q_m.size() != 0);
    if (v && q_m.size() == DEPTH) ovf_m = 1;
    if (pop) void'(q_m.pop_front());
    if (push) q_m.push_back({2'(op), c, 4'(y)});
    if (clr) begin
      acc_m = push ? y : 0;
      cnt_m = (push && c) ? 1 : 0;
    end else if (push) begin
      acc_m = (acc_m + y) % (1 << ACC_W);
      if (c && cnt_m < 15) cnt_m++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_y = 0; in_c = 0; in_op = 0; out_ready = 0; acc_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push visible next cycle
    step(1, 3, 0, 0, 0, 0);
    chk("first_out_data", out_data, 7'b0000011);
    chk("first_acc", acc, 3);
    idle();
    // Drain, then fill to full with overflow attempt
    step(0, 0, 0, 0, 1, 0);
    step(1, 2, 0, 0, 0, 1);
    step(1, 4, 1, 1, 0, 0);
    step(1, 6, 0, 2, 0, 0);
    step(1, 8, 1, 3, 0, 0);
    chk("full_level", level, 4);
    chk("full_acc", acc, 20);
    chk("full_carry", carry_cnt, 2);
    step(1, 9, 1, 0, 0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_acc", acc, 20);
    // Pop while full with in_valid: no push allowed
    step(1, 7, 0, 0, 1, 0);
    chk("full_pop_level", level, 3);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("drain_empty", out_valid, 0);
    chk("drain_acc", acc, 20);
    // Level 2 with simultaneous push/pop, pointers wrap
    step(1, 1, 0, 1, 0, 0);
    step(1, 2, 1, 2, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 3 + i, i[0], i % 4, 1, 0);
    chk("pp_level", level, 2);
    idle();
    // Accumulator wrap then clear-with-push
    step(1, 10, 0, 0, 1, 1);
    for (int i = 0; i < 16; i++) step(1, 15, 0, 0, 1, 0);
    chk("acc_250", acc, 250);
    step(1, 15, 1, 0, 1, 0);
    chk("acc_wrap", acc, 9);
    step(1, 5, 1, 0, 1, 1);
    chk("clr_push_acc", acc, 5);
    chk("clr_push_cnt", carry_cnt, 1);
    // Carry saturation
    for (int i = 0; i < 18; i++) step(1, 1, 1, 0, 1, 0);
    chk("cnt_sat", carry_cnt, 15);
    // Level 3 with overflow, then asynchronous reset between edges
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, i, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_ovf", overflow, 1);
    in_valid = 0; out_ready = 0; acc_clr = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_level", level, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_acc", acc, 0);
    chk("arst_carry", carry_cnt, 0);
    chk("arst_ovf", overflow, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 9, 1, 2, 0, 0);
    chk("post_rst_head", out_data, {2'd2, 1'b1, 4'd9});
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 15), $urandom_range(0, 1),
           $urandom_range(0, 3), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
